// File: rtl/elevator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevator_pkg : shared state/direction encodings and floor width       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package elevator_pkg;

  localparam int FLOOR_W = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    MOVING_UP   = 2'd1,
    MOVING_DOWN = 2'd2,
    DOOR_OPEN   = 2'd3
  } state_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  function automatic logic [FLOOR_W-1:0] step_floor(input logic [FLOOR_W-1:0] floor,
                                                    input dir_e dir);
    return (dir == UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevator_controller_if : request strobe in, car status out            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface elevator_controller_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8
);

  logic                  req_valid;
  logic [FLOOR_W-1:0]    req_floor;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  moving_up;
  logic                  moving_down;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic                  idle;

  modport master (
    output req_valid, req_floor,
    input  current_floor, moving_up, moving_down, door_open, pending, idle
  );

  modport slave (
    input  req_valid, req_floor,
    output current_floor, moving_up, moving_down, door_open, pending, idle
  );

endinterface
`default_nettype wire

// File: rtl/request_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | request_register : pending-floor bitmap with above/below/here lookup  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module request_register
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en_i,
  input  logic [FLOOR_W-1:0]    set_floor_i,
  input  logic                  clr_en_i,
  input  logic [FLOOR_W-1:0]    clr_floor_i,
  input  logic [FLOOR_W-1:0]    cur_floor_i,
  input  logic [FLOOR_W-1:0]    probe_floor_i,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  above_o,
  output logic                  below_o,
  output logic                  here_o,
  output logic                  probe_hit_o
);

  logic [NUM_FLOORS-1:0] pending_q, pending_d;

  // Clear is applied after set so a stop at a floor absorbs a same-edge request for it.
  always_comb begin
    pending_d   = pending_q;
    above_o     = 1'b0;
    below_o     = 1'b0;
    here_o      = 1'b0;
    probe_hit_o = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (set_en_i && (set_floor_i == FLOOR_W'(i))) pending_d[i] = 1'b1;
      if (clr_en_i && (clr_floor_i == FLOOR_W'(i))) pending_d[i] = 1'b0;
      if (pending_q[i]) begin
        if (FLOOR_W'(i) > cur_floor_i)    above_o     = 1'b1;
        if (FLOOR_W'(i) < cur_floor_i)    below_o     = 1'b1;
        if (FLOOR_W'(i) == cur_floor_i)   here_o      = 1'b1;
        if (FLOOR_W'(i) == probe_floor_i) probe_hit_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule
`default_nettype wire

// File: rtl/elevator_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevator_controller : single-car SCAN scheduler with door hold        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  elevator_controller_if.slave bus
);

  localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  dir_e                  dir_q, dir_d;
  logic [TRAVEL_W-1:0]   travel_q, travel_d;
  logic [DOOR_W-1:0]     door_q, door_d;

  logic                  req_in_range, req_here_door, set_en, clr_en;
  logic [FLOOR_W-1:0]    clr_floor, probe_floor;
  logic                  above, below, here, probe_hit;
  logic [NUM_FLOORS-1:0] pending;

  // Widened compare so NUM_FLOORS=16 does not wrap to zero.
  assign req_in_range  = bus.req_valid &&
                         ({1'b0, bus.req_floor} < (FLOOR_W+1)'(NUM_FLOORS));
  assign req_here_door = req_in_range && (state_q == DOOR_OPEN) && (bus.req_floor == floor_q);
  assign set_en        = req_in_range && !req_here_door;
  assign probe_floor   = step_floor(floor_q, (state_q == MOVING_DOWN) ? DOWN : UP);

  request_register #(
    .NUM_FLOORS(NUM_FLOORS)
  ) u_request_register (
    .clk          (clk),
    .reset        (reset),
    .set_en_i     (set_en),
    .set_floor_i  (bus.req_floor),
    .clr_en_i     (clr_en),
    .clr_floor_i  (clr_floor),
    .cur_floor_i  (floor_q),
    .probe_floor_i(probe_floor),
    .pending_o    (pending),
    .above_o      (above),
    .below_o      (below),
    .here_o       (here),
    .probe_hit_o  (probe_hit)
  );

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    travel_d  = travel_q;
    door_d    = door_q;
    clr_en    = 1'b0;
    clr_floor = floor_q;
    unique case (state_q)
      IDLE: begin
        if (here) begin
          state_d = DOOR_OPEN;
          door_d  = '0;
          clr_en  = 1'b1;
        end else if (above) begin
          state_d  = MOVING_UP;
          travel_d = '0;
        end else if (below) begin
          state_d  = MOVING_DOWN;
          travel_d = '0;
        end
      end
      MOVING_UP, MOVING_DOWN: begin
        if (travel_q == TRAVEL_W'(TRAVEL_CYCLES - 1)) begin
          floor_d  = probe_floor;
          travel_d = '0;
          dir_d    = (state_q == MOVING_UP) ? UP : DOWN;
          if (probe_hit) begin
            state_d   = DOOR_OPEN;
            door_d    = '0;
            clr_en    = 1'b1;
            clr_floor = probe_floor;
          end
        end else begin
          travel_d = travel_q + TRAVEL_W'(1);
        end
      end
      DOOR_OPEN: begin
        if (req_here_door) begin
          door_d = '0;
        end else if (door_q == DOOR_W'(DOOR_CYCLES - 1)) begin
          door_d   = '0;
          travel_d = '0;
          if ((dir_q == UP) ? above : below)
            state_d = (dir_q == UP) ? MOVING_UP : MOVING_DOWN;
          else if ((dir_q == UP) ? below : above)
            state_d = (dir_q == UP) ? MOVING_DOWN : MOVING_UP;
          else
            state_d = IDLE;
        end else begin
          door_d = door_q + DOOR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      floor_q  <= '0;
      dir_q    <= UP;
      travel_q <= '0;
      door_q   <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      travel_q <= travel_d;
      door_q   <= door_d;
    end
  end

  assign bus.current_floor = floor_q;
  assign bus.moving_up     = (state_q == MOVING_UP);
  assign bus.moving_down   = (state_q == MOVING_DOWN);
  assign bus.door_open     = (state_q == DOOR_OPEN);
  assign bus.idle          = (state_q == IDLE);
  assign bus.pending       = pending;

endmodule
`default_nettype wire

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
- Single-car elevator scheduler: latches floor requests, moves the car one floor per travel interval, and holds the door open on arrival.
- Sits directly upstream of the 7-segment display decoder. Its `current_floor` output drives the decoder's `floor_number` input unchanged.
- Uses SCAN (elevator-algorithm) ordering.

Parameters:
- NUM_FLOORS, 8, number of served floors (2..16); floor indices 0..NUM_FLOORS-1.
- TRAVEL_CYCLES, 4, clock cycles spent moving between adjacent floors (>=1).
- DOOR_CYCLES, 3, clock cycles door_open stays high per stop (>=1).

Ports:
- Interface (decided): one clock `clk`; `reset` is asynchronous and active-high.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request strobe, sampled each rising edge.
- req_floor  input  4  requested floor; ignored when >= NUM_FLOORS.
- current_floor  output  4  car position; feeds the display decoder.
- moving_up  output  1  high while state is MOVING_UP.
- moving_down  output  1  high while state is MOVING_DOWN.
- door_open  output  1  high while state is DOOR_OPEN.
- pending  output  NUM_FLOORS  outstanding request bitmap.
- idle  output  1  high while state is IDLE.

Behaviour:
- Reset (async): state=IDLE, current_floor=0, pending=0, last_dir=UP, travel and door counters=0. All outputs 0 except idle=1.
- Request capture:
  - req_valid with an in-range floor sets pending[req_floor] at that edge; visible the next cycle.
  - Out-of-range requests are dropped silently.
  - A request for current_floor while door_open is not latched; instead the door counter reloads, so the door stays open another DOOR_CYCLES.
  - A request for current_floor while IDLE sets the pending bit.
- States: IDLE, MOVING_UP, MOVING_DOWN, DOOR_OPEN.
- Derived terms (from the registered pending vector and current_floor):
  - above = any pending bit > current_floor
  - below = any pending bit < current_floor
  - here = pending[current_floor]
- IDLE:
  - here -> DOOR_OPEN, clearing the bit at the same edge.
  - Else above -> MOVING_UP.
  - Else below -> MOVING_DOWN.
  - Priority order is here > above > below.
- MOVING_x:
  - Travel counter starts at 0 on entry and increments each cycle.
  - At the edge where the counter equals TRAVEL_CYCLES-1, current_floor steps by ±1, the counter clears, and last_dir is set.
  - At that edge, if the new floor is pending: go to DOOR_OPEN and clear the bit at the same edge.
  - Otherwise continue in the same direction; requests ahead are guaranteed by construction.
  - Floor never wraps. The bench asserts current_floor stays within 0..NUM_FLOORS-1.
- DOOR_OPEN:
  - door_open is high exactly DOOR_CYCLES cycles, absent reloads.
  - On expiry, evaluate in order:
    - requests ahead in last_dir -> continue that direction;
    - else requests behind -> reverse;
    - else -> IDLE.
- Same-edge set and clear of one pending bit (request arrives at the stop edge for that floor): the clear wins and the door services it.
- Requests arriving mid-travel are latched. A request for a floor passed later in the sweep stops the car there.
- Reset asserted mid-travel or mid-door aborts immediately to reset values. Pending requests are lost.

Decomposition:
- Package elevator_pkg holds:
  - state encoding (2-bit: IDLE=0, MOVING_UP=1, MOVING_DOWN=2, DOOR_OPEN=3);
  - direction constants UP/DOWN;
  - floor width constant FLOOR_W=4, shared with the display decoder.
- One natural sub-module, request_register:
  - holds the pending bitmap with set/clear ports;
  - computes above/below/here combinationally for a given current_floor.
- The FSM, travel counter and door counter stay in elevator_controller.

Test Plan:
- Reset: assert reset mid-simulation while moving -> current_floor=0, pending=0, idle=1, door_open=0 immediately (no clock needed).
- Single request: from floor 0, req_floor=3 at edge E.
  - pending[3]=1 after E; moving_up after E+1.
  - current_floor reaches 1, 2, 3 at E+5, E+9, E+13.
  - door_open high for cycles E+13..E+15; idle=1 at E+16; pending=0.
- SCAN ordering: car at floor 4 moving up; requests for 2 and 6 latched.
  - Stops at 6 first, then reverses and stops at 2.
  - Floor sequence 4,5,6,5,4,3,2.
- Door extension: while door_open at floor 3, pulse req_floor=3 -> door_open stays high DOOR_CYCLES cycles after the pulse; pending[3] stays 0.
- Out-of-range and here: req_floor=9 when IDLE at floor 0 -> no state change.
  - Then req_floor=0 -> DOOR_OPEN for 3 cycles, then IDLE.
- Mid-travel pickup: moving up from 0 toward 7; req_floor=5 issued while between floors 2 and 3 -> stop at 5 (door 3 cycles), then resume to 7.
